// File: rtl/sc_axiip_pkg.sv
// sc_axiip_pkg
// Types and helpers shared by the AXI-IP slave controller and the blocks
// that sit behind its register interface.
//   axi_burst      : AXI burst type encoding
//   rd_st          : read FSM states of the register RAM
//   AXI_DATA_UNIT  : log2 of the data-bus width in bytes (byte->word shift)
package sc_axiip_pkg;

    typedef enum logic [1:0] {
        AXI_FIXED = 2'b00,
        AXI_INCR  = 2'b01,
        AXI_WRAP  = 2'b10
    } axi_burst;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_DONE
    } rd_st;

    function automatic int AXI_DATA_UNIT(input int data_byte);
        return $clog2(data_byte);
    endfunction

endpackage

// File: rtl/sc_axiip_regram_if.sv
// sc_axiip_regram_if
// Register-interface bundle between the AXI slave controller (master) and a
// register/memory consumer (slave).
//   REG_WADR/WTYP/WENB/WDAT : write address, burst info, byte enables, data
//   REG_WWAT/WERR           : write wait, write error
//   REG_RADR/RTYP/RENB      : read address, burst info, request
//   REG_RDAT/RWAT/RERR      : read data, read wait, read error
interface sc_axiip_regram_if #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_BYTE  = 4
);
    import sc_axiip_pkg::*;

    logic [AXI_ADDR_WIDTH-1:0]  REG_WADR;
    logic [9:0]                 REG_WTYP;
    logic [AXI_DATA_BYTE-1:0]   REG_WENB;
    logic [AXI_DATA_BYTE*8-1:0] REG_WDAT;
    logic                       REG_WWAT;
    logic                       REG_WERR;
    logic [AXI_ADDR_WIDTH-1:0]  REG_RADR;
    logic [9:0]                 REG_RTYP;
    logic                       REG_RENB;
    logic [AXI_DATA_BYTE*8-1:0] REG_RDAT;
    logic                       REG_RWAT;
    logic                       REG_RERR;

    modport master (
        output REG_WADR, REG_WTYP, REG_WENB, REG_WDAT,
        output REG_RADR, REG_RTYP, REG_RENB,
        input  REG_WWAT, REG_WERR, REG_RDAT, REG_RWAT, REG_RERR
    );

    modport slave (
        input  REG_WADR, REG_WTYP, REG_WENB, REG_WDAT,
        input  REG_RADR, REG_RTYP, REG_RENB,
        output REG_WWAT, REG_WERR, REG_RDAT, REG_RWAT, REG_RERR
    );

endinterface

// File: rtl/sc_axiip_spram.sv
// sc_axiip_spram
// Single-port byte-enable RAM with an RD_LAT-deep output pipeline.
//   clk_i, rst_i : clock, synchronous active-high reset (output stage only)
//   wen_i        : per-byte write enables, addr_i selects the word
//   re_i         : read issue, samples mem[addr_i] into the first stage
//   ld_i         : load strobe of the final (output) stage
//   rzero_i      : force the loaded output word to zero
//   wdat_i       : write data
//   rdat_o       : read data, held between ld_i strobes
module sc_axiip_spram #(
    parameter int DATA_BYTE = 4,
    parameter int WORDS     = 1024,
    parameter int RD_LAT    = 1
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic [DATA_BYTE-1:0]                    wen_i,
    input  logic                                    re_i,
    input  logic                                    ld_i,
    input  logic                                    rzero_i,
    input  logic [((WORDS > 1) ? $clog2(WORDS) : 1)-1:0] addr_i,
    input  logic [DATA_BYTE*8-1:0]                  wdat_i,
    output logic [DATA_BYTE*8-1:0]                  rdat_o
);
    import sc_axiip_pkg::*;

    localparam int DW = DATA_BYTE * 8;

    logic [DW-1:0] mem_q [WORDS];
    logic [DW-1:0] mem_rd;

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < DATA_BYTE; b++) begin
            if (wen_i[b]) begin
                mem_q[addr_i][b*8 +: 8] <= wdat_i[b*8 +: 8];
            end
        end
    end

    // Read-first: the first stage samples the word as it was before any
    // write on the same edge.
    assign mem_rd = mem_q[addr_i];

    for (genvar k = 0; k < RD_LAT; k++) begin : g_stage
        logic [DW-1:0] dat_q;
        logic [DW-1:0] src;
        logic          en;

        if (k == 0) begin : g_src_mem
            assign src = mem_rd;
        end else begin : g_src_prev
            assign src = g_stage[k-1].dat_q;
        end

        // stage k boundary
        if (k == RD_LAT - 1) begin : g_out
            // Output stage only moves on ld_i so the word is held between
            // completions; the first stage only moves on re_i so later
            // writes cannot leak into an in-flight read.
            assign en = (k == 0) ? (re_i & ld_i) : ld_i;
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    dat_q <= '0;
                end else if (en) begin
                    dat_q <= rzero_i ? '0 : src;
                end
            end
        end else begin : g_mid
            assign en = (k == 0) ? re_i : 1'b1;
            always_ff @(posedge clk_i) begin
                if (en) begin
                    dat_q <= src;
                end
            end
        end
    end

    assign rdat_o = g_stage[RD_LAT-1].dat_q;

endmodule

// File: rtl/sc_axiip_regram.sv
// sc_axiip_regram
// Word-addressed scratchpad RAM behind the AXI slave controller's register
// interface. Writes complete with zero wait states; reads take RD_LAT+1
// cycles and lose port arbitration to a simultaneous write.
//   AXI_CLK   : clock
//   AXI_RESET : synchronous active-high reset
//   reg_if    : register interface (slave side), see sc_axiip_regram_if
module sc_axiip_regram #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_BYTE  = 4,
    parameter int MEM_WORDS      = 1024,
    parameter int RD_LAT         = 1
) (
    input  logic              AXI_CLK,
    input  logic              AXI_RESET,
    sc_axiip_regram_if.slave  reg_if
);
    import sc_axiip_pkg::*;

    localparam int         ADR_LSB  = AXI_DATA_UNIT(AXI_DATA_BYTE);
    localparam int         MAW      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

    logic [AXI_ADDR_WIDTH-1:0]  widx;
    logic [AXI_ADDR_WIDTH-1:0]  ridx;
    logic                       wr_any;
    logic                       wr_oor;
    logic                       rd_oor;
    logic                       rd_issue;
    logic                       rd_ld;
    logic                       rd_zero;
    logic [AXI_DATA_BYTE-1:0]   ram_wen;
    logic [MAW-1:0]             ram_addr;
    logic [AXI_DATA_BYTE*8-1:0] ram_rdat;
    logic                       typ_unused;

    rd_st       rd_st_q;
    logic [1:0] lat_cnt_q;
    logic       oor_flag_q;

    assign widx   = reg_if.REG_WADR >> ADR_LSB;
    assign ridx   = reg_if.REG_RADR >> ADR_LSB;
    assign wr_oor = widx >= AXI_ADDR_WIDTH'(MEM_WORDS);
    assign rd_oor = ridx >= AXI_ADDR_WIDTH'(MEM_WORDS);
    assign wr_any = |reg_if.REG_WENB;

    // Burst info carries nothing for a flat word memory.
    assign typ_unused = ^{reg_if.REG_WTYP, reg_if.REG_RTYP};

    // A write owns the single port, so a read can only issue in a write-free
    // IDLE cycle.
    assign rd_issue = (rd_st_q == R_IDLE) & reg_if.REG_RENB & ~wr_any;

    // Output stage loads on the edge that enters R_DONE.
    assign rd_ld   = ((RD_LAT == 1) & rd_issue) |
                     ((rd_st_q == R_WAIT) & (lat_cnt_q == 2'd1));
    // With RD_LAT==1 the load coincides with issue, before oor_flag_q exists.
    assign rd_zero = (rd_st_q == R_IDLE) ? rd_oor : oor_flag_q;

    assign ram_wen  = (wr_any & ~wr_oor) ? reg_if.REG_WENB : '0;
    assign ram_addr = wr_any ? widx[MAW-1:0] : ridx[MAW-1:0];

    sc_axiip_spram #(
        .DATA_BYTE (AXI_DATA_BYTE),
        .WORDS     (MEM_WORDS),
        .RD_LAT    (RD_LAT)
    ) u_spram (
        .clk_i   (AXI_CLK),
        .rst_i   (AXI_RESET),
        .wen_i   (ram_wen),
        .re_i    (rd_issue),
        .ld_i    (rd_ld),
        .rzero_i (rd_zero),
        .addr_i  (ram_addr),
        .wdat_i  (reg_if.REG_WDAT),
        .rdat_o  (ram_rdat)
    );

    always_ff @(posedge AXI_CLK) begin
        if (AXI_RESET) begin
            rd_st_q    <= R_IDLE;
            lat_cnt_q  <= 2'd0;
            oor_flag_q <= 1'b0;
        end else begin
            case (rd_st_q)
                R_IDLE: begin
                    if (rd_issue) begin
                        oor_flag_q <= rd_oor;
                        lat_cnt_q  <= LAT_INIT;
                        rd_st_q    <= (RD_LAT == 1) ? R_DONE : R_WAIT;
                    end
                end
                R_WAIT: begin
                    lat_cnt_q <= lat_cnt_q - 2'd1;
                    if (lat_cnt_q == 2'd1) begin
                        rd_st_q <= R_DONE;
                    end
                end
                R_DONE: begin
                    rd_st_q <= R_IDLE;
                end
                default: begin
                    rd_st_q <= R_IDLE;
                end
            endcase
        end
    end

    assign reg_if.REG_WWAT = 1'b0;
    assign reg_if.REG_WERR = wr_any & wr_oor;
    assign reg_if.REG_RWAT = reg_if.REG_RENB & (rd_st_q != R_DONE);
    assign reg_if.REG_RERR = (rd_st_q == R_DONE) & oor_flag_q;
    assign reg_if.REG_RDAT = ram_rdat;

endmodule

// File: tb/tb_sc_axiip_regram.sv
// tb_sc_axiip_regram
// Scoreboard bench: three DUTs (RD_LAT 1, 3, 4) share one stimulus set,
// only the selected one sees requests. Drivers push expected write errors
// and read responses; a negedge monitor pops and compares on completion.
module tb_sc_axiip_regram;
    import sc_axiip_pkg::*;

    logic        clk;
    logic        rst;
    int          sel;
    logic [31:0] wadr;
    logic [3:0]  wenb;
    logic [31:0] wdat;
    logic [31:0] radr;
    logic        renb;

    logic [31:0] m_rdat;
    logic        m_rwat;
    logic        m_rerr;
    logic        m_werr;
    logic        m_wwat;

    int n_chk;
    int n_err;

    logic [32:0] rq[$];
    logic        wq[$];

    sc_axiip_regram_if #(.AXI_ADDR_WIDTH(32), .AXI_DATA_BYTE(4)) if_l1 ();
    sc_axiip_regram_if #(.AXI_ADDR_WIDTH(32), .AXI_DATA_BYTE(4)) if_l3 ();
    sc_axiip_regram_if #(.AXI_ADDR_WIDTH(32), .AXI_DATA_BYTE(4)) if_l4 ();

    sc_axiip_regram #(.AXI_ADDR_WIDTH(32), .AXI_DATA_BYTE(4), .MEM_WORDS(1024), .RD_LAT(1))
        u_l1 (.AXI_CLK(clk), .AXI_RESET(rst), .reg_if(if_l1));
    sc_axiip_regram #(.AXI_ADDR_WIDTH(32), .AXI_DATA_BYTE(4), .MEM_WORDS(1024), .RD_LAT(3))
        u_l3 (.AXI_CLK(clk), .AXI_RESET(rst), .reg_if(if_l3));
    sc_axiip_regram #(.AXI_ADDR_WIDTH(32), .AXI_DATA_BYTE(4), .MEM_WORDS(1024), .RD_LAT(4))
        u_l4 (.AXI_CLK(clk), .AXI_RESET(rst), .reg_if(if_l4));

    assign if_l1.REG_WADR = wadr;
    assign if_l1.REG_WTYP = 10'd0;
    assign if_l1.REG_WENB = (sel == 0) ? wenb : 4'd0;
    assign if_l1.REG_WDAT = wdat;
    assign if_l1.REG_RADR = radr;
    assign if_l1.REG_RTYP = 10'd0;
    assign if_l1.REG_RENB = (sel == 0) & renb;

    assign if_l3.REG_WADR = wadr;
    assign if_l3.REG_WTYP = 10'd0;
    assign if_l3.REG_WENB = (sel == 1) ? wenb : 4'd0;
    assign if_l3.REG_WDAT = wdat;
    assign if_l3.REG_RADR = radr;
    assign if_l3.REG_RTYP = 10'd0;
    assign if_l3.REG_RENB = (sel == 1) & renb;

    assign if_l4.REG_WADR = wadr;
    assign if_l4.REG_WTYP = 10'd0;
    assign if_l4.REG_WENB = (sel == 2) ? wenb : 4'd0;
    assign if_l4.REG_WDAT = wdat;
    assign if_l4.REG_RADR = radr;
    assign if_l4.REG_RTYP = 10'd0;
    assign if_l4.REG_RENB = (sel == 2) & renb;

    assign m_rdat = (sel == 0) ? if_l1.REG_RDAT : (sel == 1) ? if_l3.REG_RDAT : if_l4.REG_RDAT;
    assign m_rwat = (sel == 0) ? if_l1.REG_RWAT : (sel == 1) ? if_l3.REG_RWAT : if_l4.REG_RWAT;
    assign m_rerr = (sel == 0) ? if_l1.REG_RERR : (sel == 1) ? if_l3.REG_RERR : if_l4.REG_RERR;
    assign m_werr = (sel == 0) ? if_l1.REG_WERR : (sel == 1) ? if_l3.REG_WERR : if_l4.REG_WERR;
    assign m_wwat = (sel == 0) ? if_l1.REG_WWAT : (sel == 1) ? if_l3.REG_WWAT : if_l4.REG_WWAT;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        n_err++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    // Monitor: compare whenever the selected DUT completes a transfer.
    always @(negedge clk) begin
        logic [32:0] e;
        logic        we;
        if (!rst) begin
            if (|wenb) begin
                if (wq.size() == 0) begin
                    fail_now("wr_unexpected");
                end else begin
                    we = wq.pop_front();
                    chk("wr_err", 32'(m_werr), 32'(we));
                    chk("wr_wat", 32'(m_wwat), 32'd0);
                end
            end
            if (renb && !m_rwat) begin
                if (rq.size() == 0) begin
                    fail_now("rd_unexpected");
                end else begin
                    e = rq.pop_front();
                    chk("rd_dat", m_rdat, e[31:0]);
                    chk("rd_err", 32'(m_rerr), 32'(e[32]));
                end
            end
        end
    end

    // Called at posedge+1; one write cycle.
    task automatic do_write(input logic [31:0] a, input logic [3:0] be,
                            input logic [31:0] d, input logic exp_err);
        wadr = a;
        wenb = be;
        wdat = d;
        wq.push_back(exp_err);
        @(posedge clk);
        #1;
        wenb = 4'd0;
    endtask

    // Waits for read completion, counting cycles from the current one.
    // Optionally drives an in-range full-word write in cycle index wcyc.
    task automatic wait_rd(input int elat, input string nm, input int wcyc,
                           input logic [31:0] wa, input logic [31:0] wd);
        int cnt;
        bit done;
        cnt  = 0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            cnt++;
            if (!m_rwat) done = 1'b1;
            @(posedge clk);
            #1;
            wenb = 4'd0;
            if (!done && cnt == wcyc) begin
                wadr = wa;
                wdat = wd;
                wenb = 4'hF;
                wq.push_back(1'b0);
            end
        end
        renb = 1'b0;
        wenb = 4'd0;
        if (!done) fail_now({nm, "_timeout"});
        else chk({nm, "_lat"}, 32'(cnt), 32'(elat));
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] ed, input logic ee,
                           input int elat, input string nm, input int wcyc,
                           input logic [31:0] wa, input logic [31:0] wd);
        radr = a;
        renb = 1'b1;
        rq.push_back({ee, ed});
        if (wcyc == 0) begin
            wadr = wa;
            wdat = wd;
            wenb = 4'hF;
            wq.push_back(1'b0);
        end
        wait_rd(elat, nm, wcyc, wa, wd);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        sel   = 0;
        rst   = 1'b1;
        wadr  = 32'd0;
        wenb  = 4'd0;
        wdat  = 32'd0;
        radr  = 32'd0;
        renb  = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rwat_idle", 32'(m_rwat), 32'd0);
        chk("rst_rerr", 32'(m_rerr), 32'd0);
        chk("rst_rdat", m_rdat, 32'd0);
        chk("rst_werr_none", 32'(m_werr), 32'd0);
        renb = 1'b1;
        wadr = 32'h1000;
        wenb = 4'hF;
        #1;
        chk("rst_rwat_follow", 32'(m_rwat), 32'd1);
        chk("rst_werr_comb", 32'(m_werr), 32'd1);
        renb = 1'b0;
        wenb = 4'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // RD_LAT = 1
        sel = 0;
        do_write(32'h10, 4'hF, 32'hDEADBEEF, 1'b0);
        do_write(32'h10, 4'h2, 32'h0000AA00, 1'b0);
        do_read(32'h10, 32'hDEADAAEF, 1'b0, 2, "l1_bytemerge", -1, 32'd0, 32'd0);
        do_write(32'h0, 4'hF, 32'hA5A5A5A5, 1'b0);
        do_write(32'hFFC, 4'hF, 32'h0BADF00D, 1'b0);
        do_write(32'h1000, 4'hF, 32'h11111111, 1'b1);
        do_write(32'h1004, 4'h1, 32'h22222222, 1'b1);
        do_read(32'hFFC, 32'h0BADF00D, 1'b0, 2, "l1_lastword", -1, 32'd0, 32'd0);
        do_read(32'h0, 32'hA5A5A5A5, 1'b0, 2, "l1_noalias", -1, 32'd0, 32'd0);
        do_read(32'h1000, 32'h0, 1'b1, 2, "l1_oor", -1, 32'd0, 32'd0);
        do_read(32'h20, 32'h00000055, 1'b0, 3, "l1_conflict", 0, 32'h20, 32'h55);

        // RD_LAT = 3
        sel = 1;
        do_write(32'h100, 4'hF, 32'h01010101, 1'b0);
        do_write(32'h104, 4'hF, 32'h02020202, 1'b0);
        do_write(32'h108, 4'hF, 32'h03030303, 1'b0);
        do_read(32'h100, 32'h01010101, 1'b0, 4, "l3_seq0", -1, 32'd0, 32'd0);
        do_read(32'h104, 32'h02020202, 1'b0, 4, "l3_seq1", -1, 32'd0, 32'd0);
        do_read(32'h108, 32'h03030303, 1'b0, 4, "l3_seq2", -1, 32'd0, 32'd0);
        do_read(32'h100, 32'h01010101, 1'b0, 4, "l3_wr_in_wait", 1, 32'h100, 32'hFFFFFFFF);
        do_read(32'h100, 32'hFFFFFFFF, 1'b0, 4, "l3_after_wr", -1, 32'd0, 32'd0);
        do_read(32'h2000, 32'h0, 1'b1, 4, "l3_oor", -1, 32'd0, 32'd0);

        // RD_LAT = 4, reset in the middle of a read
        sel = 2;
        do_write(32'h40, 4'hF, 32'hCAFEF00D, 1'b0);
        do_write(32'h44, 4'hF, 32'h12345678, 1'b0);
        do_read(32'h40, 32'hCAFEF00D, 1'b0, 5, "l4_rd", -1, 32'd0, 32'd0);
        radr = 32'h44;
        renb = 1'b1;
        rq.push_back({1'b0, 32'h12345678});
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("l4_rst_rwat", 32'(m_rwat), 32'd1);
        chk("l4_rst_rerr", 32'(m_rerr), 32'd0);
        chk("l4_rst_rdat", m_rdat, 32'd0);
        rst = 1'b0;
        wait_rd(5, "l4_reissue", -1, 32'd0, 32'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_rd_drain", 32'(rq.size()), 32'd0);
        chk("sb_wr_drain", 32'(wq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
